// File: rtl/seq_add_mul.sv
`default_nettype none
// ============================================================================
// Module      : seq_add_mul
// Description : Sequential arithmetic responder. Accepts an operand pair
//               (a, b) on a valid/ready request channel and returns a+b and
//               a*b on a valid/ready response channel. The product is built
//               with an iterative shift-add datapath, one partial product
//               per cycle, giving a fixed latency of WIDTH+1 cycles from
//               accept to out_valid.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH      operand width in bits (legal range 2..16)
// Ports
//   clk        system clock, rising-edge active
//   rst_n      asynchronous active-low reset
//   in_valid   request valid
//   in_ready   request ready, high only in IDLE
//   a, b       operands, sampled on request accept
//   out_valid  response valid, high only in DONE
//   out_ready  response ready
//   sum        registered a+b, WIDTH+1 bits
//   prod       registered a*b, 2*WIDTH bits
//   busy       high while a transaction is in flight (BUSY or DONE)
//   op_count   response handshake counter, 8 bits, wraps 255 -> 0
//              (present only when SEQ_ADD_MUL_CNT_EN is defined)
// Configuration macro
//   SEQ_ADD_MUL_CNT_EN  adds the op_count output and its counter
// ============================================================================
module seq_add_mul #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH:0]       sum,
   output logic [2*WIDTH-1:0]   prod,
   output logic                 busy
`ifdef SEQ_ADD_MUL_CNT_EN
   ,
   output logic [7:0]           op_count
`endif
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   // The step counter must be able to hold WIDTH itself: steps 0..WIDTH-1
   // accumulate partial products, and step WIDTH transfers the result.
   localparam int c_stepw = $clog2(WIDTH + 1);

   localparam logic [c_stepw-1:0] c_last_step = c_stepw'(WIDTH);
   localparam logic [c_stepw-1:0] c_step_one  = c_stepw'(1);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_busy = 2'd1;
   localparam logic [1:0] c_done = 2'd2;

   // -------------------------------------------------------------------------
   // State and datapath registers
   // -------------------------------------------------------------------------
   logic [1:0]           r_state;
   logic [2*WIDTH-1:0]   r_mcand;    // multiplicand, shifts left each step
   logic [WIDTH-1:0]     r_mplier;   // multiplier, shifts right each step
   logic [2*WIDTH-1:0]   r_acc;      // partial-product accumulator
   logic [c_stepw-1:0]   r_step;     // shift-add step counter
   logic [WIDTH:0]       r_sum;
   logic [2*WIDTH-1:0]   r_prod;

   // -------------------------------------------------------------------------
   // Combinational decode
   // -------------------------------------------------------------------------
   logic                 w_in_ready;
   logic                 w_out_valid;
   logic                 w_accept;
   logic                 w_resp_hs;
   logic [2*WIDTH-1:0]   w_partial;
   logic [2*WIDTH-1:0]   w_acc_next;

   // Handshake flags are decoded straight from the state register so that
   // an asynchronous reset drives them to their idle values immediately.
   assign w_in_ready  = (r_state == c_idle);
   assign w_out_valid = (r_state == c_done);
   assign w_accept    = in_valid  & w_in_ready;
   assign w_resp_hs   = out_ready & w_out_valid;

   // Partial product for the current step: the shifted multiplicand is added
   // only when the current multiplier LSB is set.
   assign w_partial   = r_mplier[0] ? r_mcand : '0;
   assign w_acc_next  = r_acc + w_partial;

   // -------------------------------------------------------------------------
   // Control FSM
   // -------------------------------------------------------------------------
   // IDLE -> BUSY on request accept.
   // BUSY runs WIDTH accumulate steps, then one transfer step into prod, so
   // the latency is fixed at WIDTH+1 cycles whatever the operand values.
   // DONE holds the response until the requester takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_idle;
      end else begin
         case (r_state)
            c_idle: begin
               if (w_accept) begin
                  r_state <= c_busy;
               end
            end
            c_busy: begin
               if (r_step == c_last_step) begin
                  r_state <= c_done;
               end
            end
            c_done: begin
               if (w_resp_hs) begin
                  r_state <= c_idle;
               end
            end
            default: begin
               r_state <= c_idle;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Shift-add multiplier datapath
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_step   <= '0;
      end else begin
         if (w_accept) begin
            // Multiplicand is zero-extended so that the left shifts never
            // lose bits of the 2*WIDTH-bit product.
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_step   <= '0;
         end else if ((r_state == c_busy) && (r_step != c_last_step)) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_step   <= r_step + c_step_one;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Result registers
   // -------------------------------------------------------------------------
   // sum is captured at accept and prod at DONE entry; both then hold until
   // overwritten by the next transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum  <= '0;
         r_prod <= '0;
      end else begin
         if (w_accept) begin
            // Both operands widened by one bit so the carry is kept.
            r_sum <= {1'b0, a} + {1'b0, b};
         end
         if ((r_state == c_busy) && (r_step == c_last_step)) begin
            r_prod <= r_acc;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Optional response counter
   // -------------------------------------------------------------------------
`ifdef SEQ_ADD_MUL_CNT_EN
   logic [7:0] r_op_count;

   // Free-running 8-bit count of completed responses; natural wrap 255 -> 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op_count <= '0;
      end else if (w_resp_hs) begin
         r_op_count <= r_op_count + 8'd1;
      end
   end

   assign op_count = r_op_count;
`endif

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign in_ready  = w_in_ready;
   assign out_valid = w_out_valid;
   assign busy      = (r_state != c_idle);
   assign sum       = r_sum;
   assign prod      = r_prod;

endmodule
`default_nettype wire

// File: tb/tb_seq_add_mul.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_add_mul
// Description : Self-checking bench for seq_add_mul. A driver issues
//               directed and random operand pairs and pushes the expected
//               sum/product (plain integer arithmetic) into a scoreboard
//               queue; a monitor pops and compares whenever the DUT presents
//               a response, and also checks latency, stability under
//               backpressure and the handshake flags. When
//               SEQ_ADD_MUL_CNT_EN is defined, op_count is checked as well.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_add_mul;

   localparam int WIDTH = 4;

   logic                 clk;
   logic                 rst_n;
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH:0]       sum;
   logic [2*WIDTH-1:0]   prod;
   logic                 busy;
`ifdef SEQ_ADD_MUL_CNT_EN
   logic [7:0]           op_count;
`endif

   seq_add_mul #(.WIDTH(WIDTH)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .prod      (prod),
      .busy      (busy)
`ifdef SEQ_ADD_MUL_CNT_EN
      ,
      .op_count  (op_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // -------------------------------------------------------------------------
   // Scoreboard and bookkeeping
   // -------------------------------------------------------------------------
   typedef struct {
      int s;
      int p;
      int acc_cyc;
   } exp_t;

   exp_t sb[$];

   int n_checks   = 0;
   int n_fail     = 0;
   int cyc        = 0;
   int or_mode    = 1;   // 0: out_ready low, 1: high, 2: random
   int n_sent     = 0;
   int n_resp     = 0;
   int hs_count   = 0;   // handshakes since last reset

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   initial begin : cycle_counter
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // -------------------------------------------------------------------------
   // Monitor: compares every presented response against the queue head
   // -------------------------------------------------------------------------
   initial begin : monitor
      bit   prev_valid;
      bit   prev_hs;
      bit   expect_idle;
      exp_t e;
      prev_valid  = 1'b0;
      prev_hs     = 1'b0;
      expect_idle = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_valid  = 1'b0;
            prev_hs     = 1'b0;
            expect_idle = 1'b0;
            hs_count    = 0;
            out_ready   = 1'b0;
         end else begin
            if (expect_idle) begin
               check("in_ready_after_hs", in_ready, 1);
               check("busy_after_hs", busy, 0);
               expect_idle = 1'b0;
            end
            if (prev_valid && !prev_hs) begin
               check("out_valid_held", out_valid, 1);
            end
            prev_hs = 1'b0;
            if (out_valid) begin
               if (sb.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_response: got sum %0d prod %0d expected no response (cycle %0d)",
                           sum, prod, cyc);
                  out_ready = 1'b0;
               end else begin
                  e = sb[0];
                  if (!prev_valid) begin
                     check("latency", 64'(cyc - e.acc_cyc), WIDTH + 1);
`ifdef SEQ_ADD_MUL_CNT_EN
                     check("op_count", op_count, hs_count % 256);
`endif
                  end
                  check("sum", sum, e.s);
                  check("prod", prod, e.p);
                  check("in_ready_in_done", in_ready, 0);
                  check("busy_in_done", busy, 1);
                  case (or_mode)
                     0:       out_ready = 1'b0;
                     1:       out_ready = 1'b1;
                     default: out_ready = 1'($urandom_range(0, 1));
                  endcase
                  if (out_ready) begin
                     void'(sb.pop_front());
                     hs_count++;
                     n_resp++;
                     prev_hs     = 1'b1;
                     expect_idle = 1'b1;
                  end
               end
            end else begin
               out_ready = (or_mode == 1);
            end
            prev_valid = out_valid;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Driver tasks (called and returning at a falling edge)
   // -------------------------------------------------------------------------
   task automatic send(input int av, input int bv, input bit push);
      int   n;
      exp_t e;
      in_valid = 1'b1;
      a        = WIDTH'(av);
      b        = WIDTH'(bv);
      n        = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("accept_timeout", in_ready, 1);
         in_valid = 1'b0;
      end else begin
         // Accepted on the next rising edge.
         if (push) begin
            e.s       = av + bv;
            e.p       = av * bv;
            e.acc_cyc = cyc + 1;
            sb.push_back(e);
            n_sent++;
         end
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", sb.size(), 0);
      @(negedge clk);
   endtask

   task automatic set_mode(input int m);
      @(posedge clk);
      #1;
      or_mode = m;
      @(negedge clk);
   endtask

   // -------------------------------------------------------------------------
   // Stimulus
   // -------------------------------------------------------------------------
   initial begin : stimulus
      int n;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_sum", sum, 0);
      check("rst_prod", prod, 0);
`ifdef SEQ_ADD_MUL_CNT_EN
      check("rst_op_count", op_count, 0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      // Single transaction.
      send(3, 3, 1'b1);
      drain();

      // Back-to-back.
      send(1, 2, 1'b1);
      send(3, 2, 1'b1);
      send(4, 5, 1'b1);
      drain();

      // Boundaries: maximum operands, zero multiplicand.
      send(15, 15, 1'b1);
      send(0, 9, 1'b1);
      send(9, 0, 1'b1);
      drain();

      // Backpressure: hold out_ready low for 6 cycles after out_valid.
      set_mode(0);
      send(7, 6, 1'b1);
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("bp_valid_seen", out_valid, 1);
      repeat (6) @(negedge clk);
      set_mode(1);
      drain();

      // Second request held during the first transaction.
      send(2, 2, 1'b1);
      send(9, 9, 1'b1);
      drain();

      // Random operands with random backpressure.
      set_mode(2);
      for (int i = 0; i < 40; i++) begin
         send(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain();
      set_mode(1);

      // Reset two cycles after an accept drops the transaction.
      send(5, 5, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_sum", sum, 0);
      check("mid_rst_prod", prod, 0);
`ifdef SEQ_ADD_MUL_CNT_EN
      check("mid_rst_op_count", op_count, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);   // monitor flags any stray response

      // 256 transactions after reset: op_count wraps back to 0.
      set_mode(2);
      for (int i = 0; i < 256; i++) begin
         send(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b1);
      end
      drain();
      set_mode(1);
      @(negedge clk);
`ifdef SEQ_ADD_MUL_CNT_EN
      check("op_count_wrap", op_count, 0);
`endif
      check("resp_count", n_resp, n_sent);
      check("final_in_ready", in_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seq_add_mul.md
Name: seq_add_mul

Overview:
- Sequential arithmetic responder. Accepts an operand pair (a, b) over a valid/ready request interface.
- Returns the sum and product over a valid/ready response interface.
- The product uses an iterative shift-add datapath, one partial product per cycle.
- This is the DUT-side end of the operand-driver / add / mul stimulus flow in our verification environment.

Parameters:
- WIDTH, 4, operand width in bits. Sum is WIDTH+1 bits; product is 2*WIDTH bits. Legal range 2..16.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  request ready; high only in IDLE
- a  input  WIDTH  operand a, sampled on accept
- b  input  WIDTH  operand b, sampled on accept
- out_valid  output  1  response valid; high only in DONE
- out_ready  input  1  response ready
- sum  output  WIDTH+1  registered a+b
- prod  output  2*WIDTH  registered a*b
- busy  output  1  high in BUSY or DONE

Behaviour:
- Reset: asynchronous, on rst_n low.
  - State goes to IDLE.
  - in_ready=1, out_valid=0, busy=0, sum=0, prod=0.
  - Internal accumulator, shift registers and step counter cleared.
- Deassertion of rst_n is synchronised externally; the block sees it as an ordinary edge.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - Accept when in_valid && in_ready at a rising edge.
  - On accept: latch a into multiplicand register (zero-extended to 2*WIDTH) and b into multiplier register.
  - On accept: sum <= a+b at full WIDTH+1 width, no truncation. Clear accumulator; step counter <= 0; go to BUSY.
- BUSY: in_ready=0, busy=1. Each cycle:
  - If multiplier LSB is 1, accumulator += multiplicand.
  - Multiplicand shifts left 1; multiplier shifts right 1; counter increments.
  - After exactly WIDTH BUSY cycles: prod <= final accumulator; go to DONE.
- Latency: accept at edge k gives out_valid high after edge k+WIDTH+1, i.e. WIDTH+1 cycles. Fixed and independent of operand values; no early exit on zero multiplier.
- DONE:
  - out_valid=1; sum and prod stable.
  - Stays in DONE while out_ready=0 (backpressure).
  - On out_valid && out_ready at an edge: go to IDLE, out_valid=0.
  - in_ready rises the cycle after the handshake. No same-cycle response-to-request turnaround.
- sum and prod hold the last result in IDLE and BUSY until overwritten. sum updates at accept, prod at DONE entry. Bench checks them only while out_valid=1.
- in_valid during BUSY or DONE is ignored; operands are not sampled. Requester must hold in_valid until in_ready.
- Product width: 2*WIDTH holds the maximum (2^WIDTH-1)^2 with no overflow. Accumulator is 2*WIDTH bits.
- Reset mid-BUSY or mid-DONE: transaction dropped, all outputs go to reset values immediately (asynchronous). No response is emitted.
- No X propagation: all state registers have reset values.

Optional Feature:
- Macro: SEQ_ADD_MUL_CNT_EN.
- Defined:
  - Adds output port op_count [7:0].
  - Increments by 1 on each response handshake (out_valid && out_ready); wraps 255 -> 0.
  - Reset value 0; cleared by rst_n.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then a=3, b=3 with out_ready=1 -> out_valid rises 5 cycles after accept, sum=6, prod=9, in_ready returns the cycle after the handshake.
- Back-to-back a=1,b=2; a=3,b=2; a=4,b=5 -> sum 3,5,9; prod 2,6,20. Responses in order; each accept only when in_ready=1.
- Boundary a=15, b=15 -> sum=30, prod=225. Also a=0, b=9 -> sum=9, prod=0, still 5-cycle latency.
- Backpressure: a=7, b=6, out_ready low for 6 cycles after out_valid -> out_valid held; sum=13 and prod=42 stable every cycle; completes on out_ready.
- in_valid held high with a=9, b=9 during BUSY of a=2, b=2 -> second pair accepted only after first response (sum=4/prod=4, then 18/81).
- rst_n pulsed low 2 cycles after accept of a=5, b=5 -> outputs at reset values at once; no out_valid; with SEQ_ADD_MUL_CNT_EN, op_count=0. Then 256 transactions -> op_count wraps to 0.
